// File: rtl/uart_pkg.sv
// uart_pkg: shared types and encodings for the UART transmit path.
// FSM state enum, data/stop/parity encodings and a width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_CTS = 3'd2,
    ST_SEND     = 3'd3,
    ST_GAP      = 3'd4
  } tx_state_e;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  localparam logic PARITY_EVEN = 1'b1;
  localparam logic PARITY_ODD  = 1'b0;

  localparam logic STOP_1 = 1'b0;
  localparam logic STOP_2 = 1'b1;

  function automatic logic [3:0] data_bits(input logic [1:0] enc);
    logic [3:0] n;
    n = 4'd8;
    unique case (enc)
      DBITS_5: n = 4'd5;
      DBITS_6: n = 4'd6;
      DBITS_7: n = 4'd7;
      DBITS_8: n = 4'd8;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with flush, registered status and overflow pulse.
// Head entry is presented combinationally so a pop can capture it.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          push_ok, pop_ok;

  // Next pointers, occupancy and status; flush beats any push.
  always_comb begin
    push_ok  = push && !full_q && !flush;
    pop_ok   = pop && !empty_q;
    ovf_d    = push && full_q && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + LW'(push_ok) - LW'(pop_ok);
    end
    full_d  = (cnt_d == LW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // Pointer, count and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: buffers bytes, latches frame config, gates on CTS.
// Optional CTS wait timeout built when UART_TX_CTS_TIMEOUT_EN is defined.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int CTS_TIMEOUT = 65535
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          tx_enable,
  input  logic                          flush,
  input  logic [1:0]                    cfg_data_bit_num,
  input  logic                          cfg_stop_bit_num,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_type,
  input  logic                          cts_n,
  input  logic                          tx_done,
  output logic                          start_tx,
  output logic [7:0]                    tx_data,
  output logic [1:0]                    data_bit_num,
  output logic                          stop_bit_num,
  output logic                          parity_en,
  output logic                          parity_type,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          wr_overflow,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          cts_timeout
);

  tx_state_e  state_q, state_d;
  logic       cts_s1_q, cts_s2_q;
  logic       cts_ok;
  logic       pop;
  logic [7:0] head;
  logic [7:0] tx_data_q, tx_data_d;
  logic [1:0] dbn_q, dbn_d;
  logic       sbn_q, sbn_d;
  logic       pen_q, pen_d;
  logic       pty_q, pty_d;
  logic       to_hit;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .flush     (flush),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .overflow  (wr_overflow)
  );

  // Two-flop synchronizer for the asynchronous CTS input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      cts_s1_q <= cts_n;
      cts_s2_q <= cts_s1_q;
    end
  end

  assign cts_ok = !cts_s2_q;

`ifdef UART_TX_CTS_TIMEOUT_EN
  localparam int CW = $clog2(CTS_TIMEOUT + 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          cts_to_q, cts_to_d;

  // Wait counter runs only in WAIT_CTS; sticky flag clears on flush.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == ST_WAIT_CTS) wait_cnt_d = wait_cnt_q + CW'(1);
    to_hit = (state_q == ST_WAIT_CTS) && !cts_ok &&
             (wait_cnt_q == CW'(CTS_TIMEOUT - 1));
    cts_to_d = cts_to_q;
    if (flush)       cts_to_d = 1'b0;
    else if (to_hit) cts_to_d = 1'b1;
  end

  // Timeout counter and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      cts_to_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      cts_to_q   <= cts_to_d;
    end
  end

  assign cts_timeout = cts_to_q;
`else
  logic unused_cts_timeout;

  assign to_hit             = 1'b0;
  assign cts_timeout        = 1'b0;
  assign unused_cts_timeout = |CTS_TIMEOUT;
`endif

  // Frame sequencer: claim a byte, wait for CTS, hold request, gap.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    tx_data_d = tx_data_q;
    dbn_d     = dbn_q;
    sbn_d     = sbn_q;
    pen_d     = pen_q;
    pty_d     = pty_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_enable && !fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
        end else begin
          pop       = 1'b1;
          tx_data_d = head;
          dbn_d     = cfg_data_bit_num;
          sbn_d     = cfg_stop_bit_num;
          pen_d     = cfg_parity_en;
          pty_d     = cfg_parity_type;
          state_d   = ST_WAIT_CTS;
        end
      end
      ST_WAIT_CTS: begin
        if (flush)       state_d = ST_IDLE;
        else if (cts_ok) state_d = ST_SEND;
        else if (to_hit) state_d = ST_IDLE;
      end
      ST_SEND: begin
        if (tx_done) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched frame data/config registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      dbn_q     <= DBITS_5;
      sbn_q     <= STOP_1;
      pen_q     <= 1'b0;
      pty_q     <= PARITY_ODD;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      dbn_q     <= dbn_d;
      sbn_q     <= sbn_d;
      pen_q     <= pen_d;
      pty_q     <= pty_d;
    end
  end

  assign start_tx     = (state_q == ST_SEND);
  assign frame_done   = (state_q == ST_GAP);
  assign busy         = (state_q != ST_IDLE);
  assign tx_data      = tx_data_q;
  assign data_bit_num = dbn_q;
  assign stop_bit_num = sbn_q;
  assign parity_en    = pen_q;
  assign parity_type  = pty_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed and random checks of uart_tx_ctrl.
// Frame-level reference model compared on every clock.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int D      = 16;
  localparam int CTS_TO = 20;
  localparam int LW     = $clog2(D) + 1;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_WAIT = 2;
  localparam int P_SEND = 3;
  localparam int P_GAP  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_enable;
  logic          flush;
  logic [1:0]    cfg_data_bit_num;
  logic          cfg_stop_bit_num;
  logic          cfg_parity_en;
  logic          cfg_parity_type;
  logic          cts_n;
  logic          tx_done;
  logic          start_tx;
  logic [7:0]    tx_data;
  logic [1:0]    data_bit_num;
  logic          stop_bit_num;
  logic          parity_en;
  logic          parity_type;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          wr_overflow;
  logic          busy;
  logic          frame_done;
  logic          cts_timeout;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .FIFO_DEPTH  (D),
    .CTS_TIMEOUT (CTS_TO)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .tx_enable        (tx_enable),
    .flush            (flush),
    .cfg_data_bit_num (cfg_data_bit_num),
    .cfg_stop_bit_num (cfg_stop_bit_num),
    .cfg_parity_en    (cfg_parity_en),
    .cfg_parity_type  (cfg_parity_type),
    .cts_n            (cts_n),
    .tx_done          (tx_done),
    .start_tx         (start_tx),
    .tx_data          (tx_data),
    .data_bit_num     (data_bit_num),
    .stop_bit_num     (stop_bit_num),
    .parity_en        (parity_en),
    .parity_type      (parity_type),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .fifo_level       (fifo_level),
    .wr_overflow      (wr_overflow),
    .busy             (busy),
    .frame_done       (frame_done),
    .cts_timeout      (cts_timeout)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int fd_cnt = 0;

  logic [24:0] dut_vec;
  logic [24:0] exp_vec;
  localparam logic [24:0] RST_VEC =
    {1'b0, 8'h00, 2'b00, 3'b000, 1'b0, 1'b1, 5'd0, 4'b0000};

  assign dut_vec = {start_tx, tx_data, data_bit_num, stop_bit_num,
                    parity_en, parity_type, fifo_full, fifo_empty,
                    fifo_level, wr_overflow, busy, frame_done,
                    cts_timeout};

  // Reference model: byte queue, frame phase, CTS seen two edges late.
  byte unsigned mq[$];
  int          ph;
  int          m_wait;
  logic        m_s1, m_s2;
  logic [7:0]  m_data;
  logic [1:0]  m_dbn;
  logic        m_sbn, m_pen, m_pty, m_ovf, m_to;

  function automatic void m_reset();
    mq.delete();
    ph     = P_IDLE;
    m_wait = 0;
    m_s1   = 1'b1;
    m_s2   = 1'b1;
    m_data = '0;
    m_dbn  = '0;
    m_sbn  = 1'b0;
    m_pen  = 1'b0;
    m_pty  = 1'b0;
    m_ovf  = 1'b0;
    m_to   = 1'b0;
  endfunction

  function automatic void m_step();
    bit was_empty;
    bit was_full;
    bit grant;
    int nph;
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == D);
    grant     = !m_s2;
    nph       = ph;
    m_s2      = m_s1;
    m_s1      = cts_n;
    m_ovf     = wr_en && !flush && was_full;
    case (ph)
      P_IDLE: if (tx_enable && !was_empty) nph = P_LOAD;
      P_LOAD: begin
        if (was_empty) nph = P_IDLE;
        else begin
          m_data = mq.pop_front();
          m_dbn  = cfg_data_bit_num;
          m_sbn  = cfg_stop_bit_num;
          m_pen  = cfg_parity_en;
          m_pty  = cfg_parity_type;
          m_wait = 0;
          nph    = P_WAIT;
        end
      end
      P_WAIT: begin
        if (flush) nph = P_IDLE;
        else if (grant) nph = P_SEND;
        else begin
`ifdef UART_TX_CTS_TIMEOUT_EN
          if (m_wait == CTS_TO - 1) begin
            nph  = P_IDLE;
            m_to = 1'b1;
          end else begin
            m_wait++;
          end
`endif
        end
      end
      P_SEND: if (tx_done) nph = P_GAP;
      default: nph = P_IDLE;
    endcase
    if (wr_en && !flush && !was_full) mq.push_back(wr_data);
    if (flush) begin
      mq.delete();
      m_to = 1'b0;
    end
    ph = nph;
  endfunction

  // Per-cycle compare against the model, just after each rising edge.
  always @(posedge clk) begin
    if (!reset_n) m_reset();
    else m_step();
    exp_vec = {ph == P_SEND, m_data, m_dbn, m_sbn, m_pen, m_pty,
               mq.size() == D, mq.size() == 0, LW'(mq.size()),
               m_ovf, ph != P_IDLE, ph == P_GAP, m_to};
    #1;
    if (reset_n) begin
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t: got %h expected %h",
                 $time, dut_vec, exp_vec);
      end
    end
  end

  // Count frame_done pulses seen during each completed cycle.
  always @(posedge clk) begin
    if (reset_n && frame_done) fd_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_start(input string nm, output int k);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (start_tx) begin
        k = i;
        break;
      end
    end
    n_vec++;
    if (k == 0) begin
      n_err++;
      $display("FAIL %s: start_tx got 0 expected 1 within 200", nm);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  initial begin
    int k;
    int fd0;
    logic [7:0] bytes [3];
    bytes[0] = 8'h11;
    bytes[1] = 8'h22;
    bytes[2] = 8'h33;
    reset_n          = 1'b0;
    wr_en            = 1'b0;
    wr_data          = '0;
    tx_enable        = 1'b0;
    flush            = 1'b0;
    cfg_data_bit_num = DBITS_8;
    cfg_stop_bit_num = STOP_1;
    cfg_parity_en    = 1'b0;
    cfg_parity_type  = PARITY_EVEN;
    cts_n            = 1'b1;
    tx_done          = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_vec", dut_vec, RST_VEC);
    reset_n = 1'b1;

    // Single frame latency and handshake
    cts_n = 1'b0;
    wr(8'hA5);
    @(negedge clk);
    chk("t1_level", fifo_level, 1);
    tx_enable = 1'b1;
    wait_start("t1", k);
    chk("t1_latency", k, 3);
    chk("t1_data", tx_data, 8'hA5);
    pulse_done();
    chk("t1_frame_done", frame_done, 1);
    chk("t1_start_low", start_tx, 0);
    chk("t1_empty", fifo_empty, 1);
    @(negedge clk);
    chk("t1_idle", busy, 0);

    // Three frames, config changed mid-frame
    tx_enable = 1'b0;
    cfg_data_bit_num = DBITS_8;
    for (int i = 0; i < 3; i++) wr(bytes[i]);
    fd0 = fd_cnt;
    tx_enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_start("t2", k);
      chk("t2_data", tx_data, bytes[f]);
      chk("t2_dbn", data_bit_num, (f == 0) ? DBITS_8 : DBITS_5);
      if (f == 0) begin
        cfg_data_bit_num = DBITS_5;
        repeat (4) @(negedge clk);
        chk("t2_dbn_hold", data_bit_num, DBITS_8);
        chk("t2_start_hold", start_tx, 1);
      end
      pulse_done();
    end
    repeat (3) @(negedge clk);
    chk("t2_frames", fd_cnt - fd0, 3);

    // CTS held off, then released
    tx_enable = 1'b0;
    cts_n = 1'b1;
    wr(8'h55);
    tx_enable = 1'b1;
    repeat (10) @(negedge clk);
    chk("t3_no_start", start_tx, 0);
    chk("t3_busy", busy, 1);
    cts_n = 1'b0;
    wait_start("t3", k);
    chk("t3_cts_lat", (k >= 1 && k <= 3), 1);
    chk("t3_data", tx_data, 8'h55);
    pulse_done();
    repeat (2) @(negedge clk);

    // Overflow on the 17th write
    tx_enable = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h80 + i);
      @(negedge clk);
      if (i == 15) chk("t4_no_ovf", wr_overflow, 0);
    end
    wr_en = 1'b0;
    chk("t4_ovf", wr_overflow, 1);
    chk("t4_level", fifo_level, 16);
    chk("t4_full", fifo_full, 1);
    @(negedge clk);
    chk("t4_ovf_pulse", wr_overflow, 0);

    // Flush while waiting for CTS
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    tx_enable = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_busy", busy, 1);
    chk("t5_level", fifo_level, 15);
    fd0 = fd_cnt;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_level0", fifo_level, 0);
    repeat (4) @(negedge clk);
    chk("t5_no_fd", fd_cnt - fd0, 0);

    // Flush while sending
    tx_enable = 1'b0;
    cts_n = 1'b0;
    wr(8'hC1);
    wr(8'hC2);
    repeat (2) @(negedge clk);
    tx_enable = 1'b1;
    wait_start("t6", k);
    chk("t6_data", tx_data, 8'hC1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t6_level0", fifo_level, 0);
    chk("t6_still_send", start_tx, 1);
    pulse_done();
    chk("t6_fd", frame_done, 1);
    chk("t6_empty", fifo_empty, 1);

    // CTS never granted
    tx_enable = 1'b0;
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    wr(8'h77);
    tx_enable = 1'b1;
`ifdef UART_TX_CTS_TIMEOUT_EN
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (cts_timeout) begin
        k = i;
        break;
      end
    end
    chk("t7_to_cycles", k, 22);
    chk("t7_idle", busy, 0);
    chk("t7_dropped", fifo_level, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t7_to_clear", cts_timeout, 0);
`else
    repeat (40) @(negedge clk);
    chk("t7_still_wait", busy, 1);
    chk("t7_no_to", cts_timeout, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t7_flushed", busy, 0);
`endif

    // Reset in the middle of a frame
    tx_enable = 1'b0;
    cts_n = 1'b0;
    wr(8'h99);
    wr(8'hAA);
    repeat (3) @(negedge clk);
    tx_enable = 1'b1;
    wait_start("t8", k);
    reset_n = 1'b0;
    #1;
    chk("t8_reset_vec", dut_vec, RST_VEC);
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      wr_en     = ($urandom % 3) == 0;
      wr_data   = 8'($urandom);
      tx_enable = ($urandom % 8) != 0;
      flush     = ($urandom % 97) == 0;
      tx_done   = ($urandom % 5) == 0;
      if (($urandom % 12) == 0) cts_n = ~cts_n;
      if (($urandom % 20) == 0)
        {cfg_data_bit_num, cfg_stop_bit_num,
         cfg_parity_en, cfg_parity_type} = 5'($urandom);
      @(negedge clk);
    end
    wr_en     = 1'b0;
    flush     = 1'b0;
    tx_done   = 1'b0;
    tx_enable = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
